// File: rtl/pw_entry.sv
// Password entry front end: debounces enter/clear, assembles PW_LEN digits leftmost-first.
// Optional inactivity timeout in ENTERING is built when PW_ENTRY_TIMEOUT_EN is defined.
//
// state    | meaning
// IDLE     | no digits held, digit_count = 0
// ENTERING | 0 < digit_count < PW_LEN
// FULL     | digit_count = PW_LEN, entry_done high until ack or clear
module pw_entry #(
    parameter int DIGIT_W         = 4,
    parameter int PW_LEN          = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic                          clk,
    input  logic                          system_reset,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          enter_btn,
    input  logic                          clear_btn,
    input  logic                          ack,
    output logic [PW_LEN*DIGIT_W-1:0]     pw_digits,
    output logic [$clog2(PW_LEN+1)-1:0]   digit_count,
    output logic                          digit_strobe,
    output logic                          entry_done,
    output logic                          timeout_flag
);

    localparam int CW  = $clog2(PW_LEN + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ENTERING, FULL} state_t;

    state_t                        state, state_n;
    logic [PW_LEN*DIGIT_W-1:0]     digits_n;
    logic [CW-1:0]                 count_n;
    logic                          strobe_n;

    logic [1:0]     btn_raw;
    logic [1:0]     sync1, sync2, level, armed, press_ev;
    logic [DBW-1:0] db_cnt [2];
    logic           enter_ev, clear_ev;

    assign btn_raw = {clear_btn, enter_btn};

    // A button is only armed after it has been seen released for a full debounce
    // window, so a button held through reset cannot fire until pressed again.
    always_ff @(posedge clk) begin
        if (system_reset) begin
            sync1     <= '0;
            sync2     <= '0;
            level     <= '0;
            armed     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (!armed[i]) begin
                    if (sync2[i]) begin
                        db_cnt[i] <= '0;
                    end else if (db_cnt[i] == DB_LAST) begin
                        armed[i]  <= 1'b1;
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DBW'(1);
                    end
                end else if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    always_comb begin
        press_ev = '0;
        for (int i = 0; i < 2; i++) begin
            press_ev[i] = armed[i] & sync2[i] & ~level[i] & (db_cnt[i] == DB_LAST);
        end
    end

    assign enter_ev = press_ev[0];
    assign clear_ev = press_ev[1];

`ifdef PW_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt, tmo_n;
    logic          flag_q, flag_n;

    always_ff @(posedge clk) begin
        if (system_reset) begin
            tmo_cnt <= TMO_LOAD;
            flag_q  <= 1'b0;
        end else begin
            tmo_cnt <= tmo_n;
            flag_q  <= flag_n;
        end
    end

    assign timeout_flag = flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (system_reset) begin
            state        <= IDLE;
            pw_digits    <= '0;
            digit_count  <= '0;
            digit_strobe <= 1'b0;
        end else begin
            state        <= state_n;
            pw_digits    <= digits_n;
            digit_count  <= count_n;
            digit_strobe <= strobe_n;
        end
    end

    // Priority: clear > ack (FULL only) > enter > timeout.
    always_comb begin
        state_n  = state;
        digits_n = pw_digits;
        count_n  = digit_count;
        strobe_n = 1'b0;
`ifdef PW_ENTRY_TIMEOUT_EN
        tmo_n    = tmo_cnt;
        flag_n   = 1'b0;
`endif
        if (clear_ev || (ack && state == FULL)) begin
            state_n  = IDLE;
            digits_n = '0;
            count_n  = '0;
        end else if (enter_ev && state != FULL) begin
            for (int i = 0; i < PW_LEN; i++) begin
                if (digit_count == CW'(i)) begin
                    digits_n[(PW_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit_in;
                end
            end
            count_n  = digit_count + CW'(1);
            strobe_n = 1'b1;
            state_n  = (count_n == CW'(PW_LEN)) ? FULL : ENTERING;
`ifdef PW_ENTRY_TIMEOUT_EN
            tmo_n    = TMO_LOAD;
        end else if (state == ENTERING) begin
            if (tmo_cnt == '0) begin
                state_n  = IDLE;
                digits_n = '0;
                count_n  = '0;
                flag_n   = 1'b1;
            end else begin
                tmo_n = tmo_cnt - TW'(1);
            end
`endif
        end
    end

    assign entry_done = (state == FULL);

endmodule

// File: tb/tb_pw_entry.sv
// Randomised and directed bench for pw_entry with a queue-based reference model.
// Timeout scenarios are exercised when PW_ENTRY_TIMEOUT_EN is defined.
module tb_pw_entry;

    localparam int DIGIT_W = 4;
    localparam int PW_LEN  = 4;
    localparam int DB      = 4;
    localparam int TMO     = 20;
`ifdef PW_ENTRY_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        system_reset = 1'b1;
    logic [DIGIT_W-1:0]          digit_in = '0;
    logic                        enter_btn = 1'b0;
    logic                        clear_btn = 1'b0;
    logic                        ack = 1'b0;
    logic [PW_LEN*DIGIT_W-1:0]   pw_digits;
    logic [$clog2(PW_LEN+1)-1:0] digit_count;
    logic                        digit_strobe;
    logic                        entry_done;
    logic                        timeout_flag;

    pw_entry #(
        .DIGIT_W(DIGIT_W), .PW_LEN(PW_LEN),
        .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .system_reset(system_reset), .digit_in(digit_in),
        .enter_btn(enter_btn), .clear_btn(clear_btn), .ack(ack),
        .pw_digits(pw_digits), .digit_count(digit_count),
        .digit_strobe(digit_strobe), .entry_done(entry_done),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_strobe = 0;
    int n_flag = 0;

    // Reference model: raw samples travel through a 2-deep queue; a level is
    // accepted once the last DB synchronized samples all agree with it.
    bit pipe [2][$];
    bit win  [2][$];
    bit m_lvl [2];
    bit m_arm [2];
    int q_dig [$];
    int m_idle;
    bit e_strobe, e_flag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            pipe[b].delete();
            pipe[b].push_back(1'b0);
            pipe[b].push_back(1'b0);
            win[b].delete();
            m_lvl[b] = 1'b0;
            m_arm[b] = 1'b0;
        end
        q_dig.delete();
        m_idle = 0;
    endtask

    task automatic model();
        bit raw [2];
        bit ev [2];
        bit seen, full, entering;
        int ones;
        raw[0] = enter_btn;
        raw[1] = clear_btn;
        e_strobe = 1'b0;
        e_flag   = 1'b0;
        if (system_reset) begin
            model_reset();
            return;
        end
        for (int b = 0; b < 2; b++) begin
            ev[b] = 1'b0;
            pipe[b].push_back(raw[b]);
            seen = pipe[b].pop_front();
            win[b].push_back(seen);
            if (win[b].size() > DB) void'(win[b].pop_front());
            ones = 0;
            foreach (win[b][i]) ones += int'(win[b][i]);
            if (win[b].size() == DB) begin
                if (!m_arm[b]) begin
                    if (ones == 0) m_arm[b] = 1'b1;
                end else if (ones == DB && !m_lvl[b]) begin
                    m_lvl[b] = 1'b1;
                    ev[b] = 1'b1;
                end else if (ones == 0 && m_lvl[b]) begin
                    m_lvl[b] = 1'b0;
                end
            end
        end
        full     = (q_dig.size() == PW_LEN);
        entering = (q_dig.size() > 0) && !full;
        if (ev[1] || (ack && full)) begin
            q_dig.delete();
        end else if (ev[0] && !full) begin
            q_dig.push_back(int'(digit_in));
            e_strobe = 1'b1;
            m_idle = 0;
        end else if (TMO_EN && entering) begin
            m_idle++;
            if (m_idle == TMO) begin
                q_dig.delete();
                e_flag = 1'b1;
            end
        end
    endtask

    function automatic logic [PW_LEN*DIGIT_W-1:0] exp_pw();
        logic [PW_LEN*DIGIT_W-1:0] v = '0;
        for (int i = 0; i < PW_LEN; i++) begin
            v = v << DIGIT_W;
            if (i < q_dig.size()) v = v | (PW_LEN*DIGIT_W)'(q_dig[i]);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        model();
        #1;
        cyc++;
        check("pw_digits", 32'(pw_digits), 32'(exp_pw()));
        check("digit_count", 32'(digit_count), 32'(q_dig.size()));
        check("digit_strobe", 32'(digit_strobe), 32'(e_strobe));
        check("entry_done", 32'(entry_done), 32'(q_dig.size() == PW_LEN));
        check("timeout_flag", 32'(timeout_flag), 32'(e_flag));
        if (digit_strobe) n_strobe++;
        if (timeout_flag) n_flag++;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input bit clr, input logic [DIGIT_W-1:0] d, input int hi, input int lo);
        digit_in = d;
        if (clr) clear_btn = 1'b1; else enter_btn = 1'b1;
        hold(hi);
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        for (int i = 0; i < lo; i++) begin
            digit_in = DIGIT_W'($urandom);
            step();
        end
    endtask

    initial begin
        int s0, lat;
        logic [DIGIT_W-1:0] t1 [4];
        t1[0] = 4'h3; t1[1] = 4'hA; t1[2] = 4'h0; t1[3] = 4'hF;

        system_reset = 1'b1;
        hold(3);
        check("reset_pw", 32'(pw_digits), 32'h0);
        check("reset_done", 32'(entry_done), 32'h0);
        system_reset = 1'b0;
        hold(8);

        // Test 1: four digits
        s0 = n_strobe;
        for (int i = 0; i < 4; i++) begin
            press(1'b0, t1[i], 10, 10);
            check("t1_count", 32'(digit_count), 32'(i + 1));
        end
        check("t1_pw", 32'(pw_digits), 32'h3A0F);
        check("t1_done", 32'(entry_done), 32'h1);
        check("t1_strobes", 32'(n_strobe - s0), 32'd4);

        // Test 3: enter ignored while FULL, then ack
        s0 = n_strobe;
        press(1'b0, 4'h5, 10, 10);
        check("t3_pw_hold", 32'(pw_digits), 32'h3A0F);
        check("t3_no_strobe", 32'(n_strobe - s0), 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("t3_ack_pw", 32'(pw_digits), 32'h0);
        check("t3_ack_count", 32'(digit_count), 32'h0);
        check("t3_ack_done", 32'(entry_done), 32'h0);
        hold(4);

        // Test 2: short pulse and bounces around one real press
        s0 = n_strobe;
        digit_in = 4'h9;
        enter_btn = 1'b1; hold(3);
        enter_btn = 1'b0; hold(8);
        enter_btn = 1'b1; hold(2);
        enter_btn = 1'b0; hold(2);
        enter_btn = 1'b1; hold(2);
        enter_btn = 1'b0; hold(2);
        enter_btn = 1'b1;
        lat = 0;
        while (lat < 20 && n_strobe == s0) begin
            step();
            lat++;
        end
        check("t2_latency", 32'(lat), 32'd6);
        hold(4);
        enter_btn = 1'b0; hold(2);
        enter_btn = 1'b1; hold(2);
        enter_btn = 1'b0; hold(10);
        check("t2_strobes", 32'(n_strobe - s0), 32'd1);
        check("t2_pw", 32'(pw_digits), 32'h9000);

        press(1'b1, 4'h0, 10, 10);
        check("clear_count", 32'(digit_count), 32'h0);

        // Test 4: clear and enter events coincide
        press(1'b0, 4'h7, 10, 10);
        press(1'b0, 4'h1, 10, 10);
        check("t4_pw", 32'(pw_digits), 32'h7100);
        s0 = n_strobe;
        digit_in = 4'hC;
        enter_btn = 1'b1; clear_btn = 1'b1;
        hold(10);
        enter_btn = 1'b0; clear_btn = 1'b0;
        hold(10);
        check("t4_count", 32'(digit_count), 32'h0);
        check("t4_pw_clr", 32'(pw_digits), 32'h0);
        check("t4_no_strobe", 32'(n_strobe - s0), 32'd0);

        // Test 5: reset mid-entry with enter held
        press(1'b0, 4'h5, 10, 10);
        press(1'b0, 4'h6, 10, 10);
        press(1'b0, 4'h7, 10, 10);
        check("t5_count3", 32'(digit_count), 32'd3);
        enter_btn = 1'b1;
        hold(3);
        system_reset = 1'b1;
        step();
        system_reset = 1'b0;
        check("t5_pw", 32'(pw_digits), 32'h0);
        check("t5_count", 32'(digit_count), 32'h0);
        check("t5_done", 32'(entry_done), 32'h0);
        s0 = n_strobe;
        hold(15);
        check("t5_held_none", 32'(n_strobe - s0), 32'd0);
        enter_btn = 1'b0;
        hold(10);
        press(1'b0, 4'h8, 10, 10);
        check("t5_repress", 32'(n_strobe - s0), 32'd1);

`ifdef PW_ENTRY_TIMEOUT_EN
        // Test 6: inactivity timeout
        press(1'b1, 4'h0, 10, 10);
        s0 = n_flag;
        press(1'b0, 4'h2, 10, 30);
        check("t6_flag", 32'(n_flag - s0), 32'd1);
        check("t6_count", 32'(digit_count), 32'h0);
        hold(30);
        check("t6_idle_noflag", 32'(n_flag - s0), 32'd1);
`endif

        // Randomised traffic against the model
        for (int seg = 0; seg < 160; seg++) begin
            int len;
            len = $urandom_range(1, 12);
            enter_btn = 1'($urandom_range(0, 1));
            clear_btn = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < len; k++) begin
                digit_in = DIGIT_W'($urandom);
                ack = ($urandom_range(0, 7) == 0);
                system_reset = ($urandom_range(0, 199) == 0);
                step();
            end
        end
        system_reset = 1'b0;
        ack = 1'b0;
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        hold(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pw_entry.md
Name: pw_entry

Overview:
- Password entry front end; the writer side of the password-register interface that the code checker reads and compares.
- Debounces the raw enter and clear buttons.
- Captures one DIGIT_W-bit digit from the switches per enter press and assembles PW_LEN digits, leftmost first.
- Raises entry_done when all digits are in and holds it until the controller acknowledges.

Parameters:
- DIGIT_W, 4, width of one password digit.
- PW_LEN, 4, number of digits per password.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a button level change is accepted.
- TIMEOUT_CYCLES, 500000000, inactivity limit in ENTERING; used only with PW_ENTRY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- system_reset  in  1  synchronous, active-high reset.
- digit_in  in  DIGIT_W  digit value from the switches.
- enter_btn  in  1  raw enter button, active-high (already inverted from KEY).
- clear_btn  in  1  raw clear button, active-high.
- ack  in  1  consumer has taken the completed password.
- pw_digits  out  PW_LEN*DIGIT_W  slot 0 (leftmost digit) in the MSBs; unfilled slots read 0.
- digit_count  out  $clog2(PW_LEN+1)  number of digits accepted.
- digit_strobe  out  1  one-cycle pulse per accepted digit.
- entry_done  out  1  level; all PW_LEN digits present.
- timeout_flag  out  1  one-cycle pulse on inactivity clear.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous and active-high on system_reset.
  - Reset values: pw_digits=0, digit_count=0, digit_strobe=0, entry_done=0, timeout_flag=0; synchronizers, debounce counters and button state all cleared; FSM goes to IDLE.
- Debounce:
  - Each button passes through a 2-flop synchronizer, then a debouncer with a stable-level counter.
  - Accepted level changes only after DEBOUNCE_CYCLES consecutive cycles at the new synchronized level.
  - A press event is the accepted 0->1 transition; exactly one event per physical press.
  - A new event requires an accepted release first. Bounces shorter than DEBOUNCE_CYCLES produce nothing.
- Latency:
  - Press event at edge E: digit_in is sampled at E.
  - pw_digits, digit_count and digit_strobe update in the cycle after E.
  - Total from raw rise = DEBOUNCE_CYCLES+2 cycles.
- FSM states:
  - IDLE (count=0).
  - ENTERING (0<count<PW_LEN).
  - FULL (count=PW_LEN).
- Transitions and actions:
  - Enter event in IDLE or ENTERING: write digit_in to slot digit_count, increment digit_count, pulse digit_strobe.
    - IDLE -> ENTERING; ENTERING -> FULL when the new count equals PW_LEN.
    - With PW_LEN=1: IDLE -> FULL directly.
  - FULL:
    - entry_done=1, asserted in the same cycle count reaches PW_LEN.
    - Enter events are ignored: no strobe, no data change.
  - ack while FULL: next cycle pw_digits=0, count=0, entry_done=0, state IDLE. ack in any other state is ignored.
  - Clear event in any state: next cycle pw_digits=0, count=0, entry_done=0, state IDLE. No strobe.
- Same-cycle priority: system_reset > clear event > ack > enter event.
  - A dropped enter event is lost, not queued.
  - Clear and enter together: state becomes IDLE with count 0; the digit is discarded.
- digit_count never exceeds PW_LEN; no wrap-around.
- digit_in changes between events have no effect.

Optional Feature:
- Macro: PW_ENTRY_TIMEOUT_EN.
- Defined:
  - Inactivity counter runs only in ENTERING.
  - It is reset by every accepted digit and on entry to ENTERING.
  - After TIMEOUT_CYCLES cycles without an accepted digit: same action as a clear, plus timeout_flag pulses for one cycle.
  - No timeout in IDLE or FULL.
  - A clear or enter event in the expiry cycle takes priority over the timeout, and no flag is raised.
- Undefined:
  - No inactivity counter logic.
  - timeout_flag is tied to 0.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, PW_LEN=4, DIGIT_W=4.
- Test 1: reset, then press enter 4 times, each held 10 cycles, with digit_in=3,A,0,F -> one digit_strobe per press, digit_count 1..4, pw_digits=16'h3A0F, entry_done=1 exactly when count=4.
- Test 2: enter held high for only 3 cycles, plus 2-cycle bounce glitches around one real press -> exactly one strobe total; first strobe occurs 6 cycles after the raw rise.
- Test 3: while FULL, press enter again with digit_in=5 -> pw_digits stays 16'h3A0F, no strobe; then ack for 1 cycle -> next cycle pw_digits=0, count=0, entry_done=0.
- Test 4: after 2 digits (7,1) -> pw_digits=16'h7100; clear press whose event coincides with an enter event -> count=0, pw_digits=0, no strobe.
- Test 5: system_reset asserted mid-entry with count=3 and a button held -> all outputs 0 the next cycle; the held button gives no event until it is released and pressed again.
- Test 6 (PW_ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=20): enter 1 digit, then idle for 20 cycles -> timeout_flag pulses once, count=0, state IDLE. The same 20 idle cycles from IDLE -> no flag.
